arb4_rr: RTL and testbench
==========================

Name: arb4_rr

Overview:
- Round-robin arbiter and controller for the shared 4-input, 32-bit datapath multiplexer.
- Four requesters each present one data word and a request.
- The block picks one winner and drives the 2-bit mux select for it.
- It captures the selected word into an output register and hands it downstream with a valid/ready handshake.
- It sits between the four bus masters and the single shared consumer port.

Parameters:
- WIDTH, 32, data word width per requester and output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester; bit i pairs with in_i.
- in1  in  WIDTH  requester 0 data.
- in2  in  WIDTH  requester 1 data.
- in3  in  WIDTH  requester 2 data.
- in4  in  WIDTH  requester 3 data.
- gnt  out  4  one-hot grant pulse, 1 cycle: word from that requester was captured.
- sel  out  2  index of the current or last winner; drives the mux select.
- out  out  WIDTH  registered output word.
- out_valid  out  1  out holds an unconsumed word.
- out_ready  in  1  downstream accepts out this cycle when out_valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ptr=0.
  - gnt=0, sel=0, out=0, out_valid=0.
  - Any pending word is discarded; no gnt is issued for it.
- Effective request: eff = req & ~gnt. A requester cannot be granted twice on consecutive cycles.
- Winner: first set bit of eff, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Capture event, at a rising edge:
  - Condition: (state==IDLE, or out_ready=1 in BUSY) and eff!=0.
  - out <= word of winner; sel <= winner.
  - gnt <= onehot(winner); out_valid <= 1.
  - ptr <= winner+1 (2-bit natural wrap, 3→0).
  - state <= BUSY.
- Edge with no capture: gnt <= 0.
- IDLE: out_valid=0; stay in IDLE while eff==0.
- BUSY: out_valid=1; out, sel, ptr held stable while out_ready=0.
- BUSY with out_ready=1:
  - eff!=0 → back-to-back capture; stay in BUSY, full throughput of 1 word/cycle.
  - eff==0 → out_valid <= 0; state <= IDLE. out and sel keep their last values.
- Latency: req sampled at edge k → gnt and out_valid high in cycle k+1.
- Requester protocol:
  - Hold req and data stable until gnt is seen.
  - Drop req or present the next word in the gnt cycle.
- Fairness: after a grant to i, i has lowest priority; no requester waits more than 3 grants.
- Simultaneous events:
  - out_ready=1 together with new req → capture wins; out_valid stays 1.
  - req change while BUSY and out_ready=0 → ignored until the next capture opportunity.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro ARB4_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit), sampled at each capture edge.
  - If lock=1 at capture, the next capture is restricted to the same winner: eff = req & onehot(sel), with no gnt masking.
  - ptr is not advanced while locked, so the locked requester can stream back-to-back words (bursts).
  - Lock releases at the first capture with lock=0, or when the locked requester's req=0 in a capture opportunity. Then normal round-robin resumes from ptr = sel+1.
- Not defined: no lock port; pure round-robin as above.

Decomposition:
- Shared package arb4_pkg holds:
  - NREQ=4, IDX_W=2.
  - state enum {IDLE, BUSY}.
  - function onehot(idx) → 4-bit vector.
  - function rr_pick(eff, ptr) → {found, idx}.
- Natural sub-module: rr_pick4, combinational priority rotate.
  - Inputs eff[3:0], ptr[1:0]; outputs found, idx[1:0].
  - Unit-testable alone.
- Data selection reuses the existing 4-input mux, with sel driven by the winner index.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 → gnt=0, out_valid=0, sel=0, out=0 throughout.
- Single request: req=0010, in2=32'hA5A5_0001, out_ready=0 → next cycle gnt=0010, out_valid=1, out=32'hA5A5_0001, sel=1. These hold until out_ready=1, then out_valid=0.
- Round-robin: req=1111 held (requesters re-assert after gnt), out_ready=1 constant → grant order 0,1,2,3,0 on consecutive cycles; out_valid stays 1.
- Pointer wrap and masking: ptr=3 after a grant to 2, req=1001 → winner 3, then 0. With req=0001 only: back-to-back captures alternate with idle cycles because gnt masks the next cycle.
- Backpressure: req=0100, out_ready=0 for 5 cycles, in3 changes meanwhile → out keeps the first captured value; no further gnt until out_ready=1.
- Reset mid-operation: out_valid=1, rst_n pulsed low asynchronously between edges → out_valid, gnt, out, sel go to 0 immediately. The next grant after release starts from requester 0.

Source files
------------

// File: rtl/arb4_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter (arb4_rr).
package arb4_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Returns {found, idx}: first set bit of eff searching ptr, ptr+1, ... (mod 4).
  // Scanning from the far end lets the nearest candidate overwrite the result.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] eff,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    rr_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (eff[cand]) rr_pick = {1'b1, cand};
    end
  endfunction
endpackage

// File: rtl/arb4_rr_pick4.sv
// Combinational rotating priority picker: first set bit of eff starting at ptr.
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [NREQ-1:0]  eff,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  assign {found, idx} = rr_pick(eff, ptr);
endmodule

// File: rtl/arb4_rr.sv
// Round-robin arbiter driving a shared 4:1 datapath mux with a registered
// valid/ready output. Define ARB4_LOCK_EN to add the burst-lock input.
module arb4_rr
  import arb4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
`ifdef ARB4_LOCK_EN
  input  logic             lock,
`endif
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);
  // Handshake: a word in out transfers on any rising edge where
  // out_valid=1 and out_ready=1; out_ready is ignored while out_valid=0.

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  eff;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic             opp;
  logic             take;
  logic [WIDTH-1:0] mux_word;

`ifdef ARB4_LOCK_EN
  logic locked;
  // While locked only the current owner may win; gnt masking is bypassed so it can stream.
  assign eff = locked ? (req & onehot(sel)) : (req & ~gnt);
`else
  assign eff = req & ~gnt;
`endif

  rr_pick4 u_pick (
    .eff   (eff),
    .ptr   (ptr),
    .found (found),
    .idx   (win_idx)
  );

  assign opp       = (state == IDLE) || out_ready;
  assign take      = opp && found;
  assign out_valid = (state == BUSY);

  always_comb begin
    mux_word = in1;
    case (win_idx)
      2'd0: mux_word = in1;
      2'd1: mux_word = in2;
      2'd2: mux_word = in3;
      2'd3: mux_word = in4;
      default: mux_word = in1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = BUSY;
      BUSY: if (out_ready) state_nxt = take ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      sel   <= '0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= take ? onehot(win_idx) : '0;
      if (take) begin
        out <= mux_word;
        sel <= win_idx;
        ptr <= win_idx + 2'd1;
      end
    end
  end

`ifdef ARB4_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (take) begin
      locked <= lock;
    end else if (locked && opp && !req[sel]) begin
      locked <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_arb4_rr.sv
// Directed scoreboard bench for arb4_rr: stimulus pushes expected grants, a monitor pops them.
module tb_arb4_rr;
  import arb4_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [W-1:0]  in1, in2, in3, in4;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [W-1:0]  out;
  logic          out_valid;
  logic          out_ready;

  logic [38:0]   exp_q[$];
  int            passed;
  int            total;

  arb4_rr #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef ARB4_LOCK_EN
    .lock      (1'b0),
`endif
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input logic [1:0] idx, input logic [W-1:0] word);
    exp_q.push_back({onehot(idx), idx, 1'b1, word});
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_gnt"}, W'(gnt), '0);
    chk({name, "_valid"}, W'(out_valid), '0);
    chk({name, "_sel"}, W'(sel), '0);
    chk({name, "_out"}, out, '0);
  endtask

  // scoreboard monitor: every grant pulse must match the next expected capture
  always @(negedge clk) begin
    logic [38:0] e;
    if (rst_n && gnt != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL grant_unexpected: got gnt=%b sel=%0d out=%h expected no grant", gnt, sel, out);
      end else begin
        e = exp_q.pop_front();
        if ({gnt, sel, out_valid, out} === e) passed++;
        else $display("FAIL grant: got gnt=%b sel=%0d v=%b out=%h expected gnt=%b sel=%0d v=%b out=%h",
                      gnt, sel, out_valid, out, e[38:35], e[34:33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    passed = 0;
    total  = 0;
    req = '0; in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    out_ready = 1'b0;
    rst_n = 1'b0;

    // reset then idle
    repeat (2) begin
      cycle();
      chk_zero("reset");
    end
    rst_n = 1'b1;
    cycle();
    chk_zero("idle");

    // round robin with all requesting, consumer always ready
    in1 = 32'h1111_0000; in2 = 32'h2222_1111; in3 = 32'h3333_2222; in4 = 32'h4444_3333;
    out_ready = 1'b1;
    req = 4'b1111;
    exp_grant(2'd0, 32'h1111_0000);
    exp_grant(2'd1, 32'h2222_1111);
    exp_grant(2'd2, 32'h3333_2222);
    exp_grant(2'd3, 32'h4444_3333);
    exp_grant(2'd0, 32'h1111_0000);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_valid", W'(out_valid), 1);
    end
    req = '0;
    cycle();
    chk("rr_drain_valid", W'(out_valid), 0);
    chk("rr_drain_gnt", W'(gnt), 0);
    chk("rr_drain_sel", W'(sel), 0);
    chk("rr_drain_out", out, 32'h1111_0000);

    // single request held under backpressure (ptr=1)
    out_ready = 1'b0;
    req = 4'b0010;
    in2 = 32'hA5A5_0001;
    exp_grant(2'd1, 32'hA5A5_0001);
    cycle();
    req = '0;
    repeat (3) begin
      cycle();
      chk("single_hold_valid", W'(out_valid), 1);
      chk("single_hold_out", out, 32'hA5A5_0001);
      chk("single_hold_sel", W'(sel), 1);
      chk("single_hold_gnt", W'(gnt), 0);
    end
    out_ready = 1'b1;
    cycle();
    chk("single_consumed_valid", W'(out_valid), 0);
    chk("single_consumed_out", out, 32'hA5A5_0001);

    // pointer wrap 3 -> 0 and grant masking (ptr=2)
    req = 4'b0100;
    in3 = 32'h3333_0002;
    exp_grant(2'd2, 32'h3333_0002);
    cycle();
    req = 4'b1001;
    in4 = 32'h4444_0003;
    in1 = 32'h1111_0004;
    exp_grant(2'd3, 32'h4444_0003);
    cycle();
    req = 4'b0001;
    exp_grant(2'd0, 32'h1111_0004);
    cycle();
    in1 = 32'h1111_0005;
    cycle();
    chk("mask_gnt_a", W'(gnt), 0);
    chk("mask_valid_a", W'(out_valid), 0);
    exp_grant(2'd0, 32'h1111_0005);
    cycle();
    in1 = 32'h1111_0006;
    cycle();
    chk("mask_gnt_b", W'(gnt), 0);
    chk("mask_valid_b", W'(out_valid), 0);
    exp_grant(2'd0, 32'h1111_0006);
    cycle();
    req = '0;
    cycle();
    chk("mask_end_valid", W'(out_valid), 0);

    // backpressure while the winner's data keeps changing (ptr=1)
    out_ready = 1'b0;
    req = 4'b0100;
    in3 = 32'hC0DE_0003;
    exp_grant(2'd2, 32'hC0DE_0003);
    cycle();
    for (int i = 0; i < 5; i++) begin
      in3 = 32'hC0DE_0010 + W'(i);
      cycle();
      chk("bp_gnt", W'(gnt), 0);
      chk("bp_out", out, 32'hC0DE_0003);
      chk("bp_valid", W'(out_valid), 1);
    end
    chk("bp_sel", W'(sel), 2);
    in3 = 32'hC0DE_0099;
    exp_grant(2'd2, 32'hC0DE_0099);
    out_ready = 1'b1;
    cycle();
    req = '0;
    cycle();
    chk("bp_end_valid", W'(out_valid), 0);

    // asynchronous reset mid-operation (ptr=3)
    out_ready = 1'b0;
    req = 4'b1000;
    in4 = 32'h4444_0004;
    exp_grant(2'd3, 32'h4444_0004);
    cycle();
    req = '0;
    #6;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    cycle();
    rst_n = 1'b1;
    req = 4'b1111;
    out_ready = 1'b1;
    exp_grant(2'd0, 32'h1111_0006);
    cycle();
    req = '0;
    cycle();
    chk("post_rst_valid", W'(out_valid), 0);

    repeat (2) cycle();
    chk("queue_empty", W'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
